// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package instr_fetch_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] PC_RESET_DEF = 32'h8000_0000;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FLUSH = 2'd2,
      S_HOLD  = 2'd3
   } if_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding imem handshake, stall hold, redirect with
// drain of the in-flight request, and NOP substitution on bubbles and faults.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEF,
   parameter int          XLEN     = XLEN_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ack,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_imem_err,
   output logic            o_valid,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic            o_fault
);

   if_state_e       state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] pend_q, pend_d;

   logic            goto_en;
   logic [XLEN-1:0] goto_pc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= XLEN'(PC_RESET);
         valid_q <= 1'b0;
         instr_q <= INSTR_NOP;
         pc_q    <= XLEN'(PC_RESET);
         fault_q <= 1'b0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      pend_d  = pend_q;
      goto_en = 1'b0;
      goto_pc = i_redirect_pc;

      unique case (state_q)
         S_IDLE: begin
            if (i_redirect) begin
               goto_en = 1'b1;
            end else begin
               req_d   = 1'b1;
               addr_d  = XLEN'(PC_RESET);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_redirect) begin
               // Without ack the old request is still owed a completion: drain it first.
               if (i_imem_ack) begin
                  goto_en = 1'b1;
               end else begin
                  pend_d  = i_redirect_pc;
                  state_d = S_FLUSH;
               end
            end else if (i_imem_ack) begin
               valid_d = 1'b1;
               fault_d = i_imem_err;
               instr_d = i_imem_err ? INSTR_NOP : i_imem_rdata;
               pc_d    = addr_q;
               req_d   = 1'b0;
               state_d = S_HOLD;
            end
         end
         S_FLUSH: begin
            if (i_redirect) begin
               if (i_imem_ack) goto_en = 1'b1;
               else            pend_d  = i_redirect_pc;
            end else if (i_imem_ack) begin
               goto_en = 1'b1;
               goto_pc = pend_q;
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               goto_en = 1'b1;
            end else if (valid_q && !fault_q && !i_stall) begin
               valid_d = 1'b0;
               instr_d = INSTR_NOP;
               addr_d  = pc_q + XLEN'(4);
               req_d   = 1'b1;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect target: misaligned ones fault locally and never reach memory.
      if (goto_en) begin
         instr_d = INSTR_NOP;
         if (is_misaligned(goto_pc[1:0])) begin
            req_d   = 1'b0;
            valid_d = 1'b1;
            fault_d = 1'b1;
            pc_d    = goto_pc;
            state_d = S_HOLD;
         end else begin
            req_d   = 1'b1;
            addr_d  = goto_pc;
            valid_d = 1'b0;
            fault_d = 1'b0;
            state_d = S_WAIT;
         end
      end
   end

   assign o_imem_req  = req_q;
   assign o_imem_addr = addr_q;
   assign o_valid     = valid_q;
   assign o_instr     = instr_q;
   assign o_pc        = pc_q;
   assign o_fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random
// stall/redirect/latency/error traffic compared every cycle to a transaction model.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam logic [31:0] PCR = 32'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1, stall = 1'b0, redir = 1'b0;
   logic [31:0] rpc = '0;
   logic        req, ack = 1'b0, err = 1'b0;
   logic [31:0] addr, rdata = '0;
   logic        valid, fault;
   logic [31:0] instr, pc;

   always #5 clk = ~clk;

   instr_fetch #(.PC_RESET(PCR), .XLEN(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall),
      .i_redirect(redir), .i_redirect_pc(rpc),
      .o_imem_req(req), .o_imem_addr(addr),
      .i_imem_ack(ack), .i_imem_rdata(rdata), .i_imem_err(err),
      .o_valid(valid), .o_instr(instr), .o_pc(pc), .o_fault(fault)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Memory behaviour knobs
   int          mem_cnt = 0;
   int          mem_lat = 1;
   bit          mem_block = 0, rand_lat = 0, rand_data = 0, err_rand = 0, err_en = 0;
   logic [31:0] fix_data = 32'h0050_0093;
   logic [31:0] err_addr = '0;

   // Transaction-level model: what is on the bus, whether it is stale, what is presented
   bit          m_fresh, m_stale, m_req, m_valid, m_fault;
   logic [31:0] m_target, m_addr, m_instr, m_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_go(input logic [31:0] t);
      m_stale = 0;
      m_instr = NOP;
      if (t[1:0] != 2'b00) begin
         m_req = 0; m_valid = 1; m_fault = 1; m_pc = t;
      end else begin
         m_req = 1; m_addr = t; m_valid = 0; m_fault = 0;
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit rd, input logic [31:0] t,
                             input bit a, input logic [31:0] d, input bit e);
      if (r) begin
         m_fresh = 1; m_stale = 0; m_target = '0; m_req = 0; m_addr = PCR;
         m_valid = 0; m_instr = NOP; m_pc = PCR; m_fault = 0;
      end else if (m_fresh) begin
         m_fresh = 0;
         if (rd) m_go(t);
         else begin m_req = 1; m_addr = PCR; end
      end else if (rd) begin
         if (m_req && !a) begin m_stale = 1; m_target = t; end
         else m_go(t);
      end else if (m_req && a) begin
         if (m_stale) m_go(m_target);
         else begin
            m_valid = 1; m_fault = e; m_instr = e ? NOP : d; m_pc = m_addr; m_req = 0;
         end
      end else if (m_valid && !m_fault && !s) begin
         m_valid = 0; m_instr = NOP; m_req = 1; m_addr = m_pc + 32'd4;
      end
   endtask

   task automatic check_model();
      chk("req",   {31'd0, req},   {31'd0, m_req});
      chk("addr",  addr,           m_addr);
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("instr", instr,          m_instr);
      chk("pc",    pc,             m_pc);
      chk("fault", {31'd0, fault}, {31'd0, m_fault});
   endtask

   task automatic step();
      bit a, r0;
      r0 = (req === 1'b1);
      a = r0 && !mem_block && (mem_cnt >= mem_lat);
      ack = a;
      rdata = rand_data ? $urandom : fix_data;
      err = a && (err_rand ? ($urandom_range(0, 7) == 0) : (err_en && addr === err_addr));
      model_step(rst, stall, redir, rpc, a, rdata, err);
      @(posedge clk);
      #1;
      mem_cnt = (a || !r0 || rst) ? 0 : mem_cnt + 1;
      if (rand_lat && a) mem_lat = $urandom_range(0, 3);
      check_model();
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (valid !== 1'b1 && k < 20) begin step(); k++; end
      if (valid !== 1'b1) begin
         n_checks++; n_errors++;
         $display("FAIL %s: timeout, o_valid=%b required 1", name, valid);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"},   {31'd0, req},   32'd0);
      chk({tag, "_addr"},  addr,           PCR);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_instr"}, instr,          NOP);
      chk({tag, "_pc"},    pc,             PCR);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      // Reset and first fetch: ack one cycle after request
      repeat (3) step();
      chk_reset("rst");
      rst = 0;
      step();
      chk("c1_req", {31'd0, req}, 32'd1);
      chk("c1_addr", addr, PCR);
      step();
      step();
      chk("c3_valid", {31'd0, valid}, 32'd1);
      chk("c3_pc", pc, PCR);
      chk("c3_instr", instr, 32'h0050_0093);
      step();
      chk("c4_addr", addr, PCR + 32'd4);

      // Stall hold for 5 cycles
      wait_valid("w_stall");
      stall = 1;
      repeat (5) begin
         step();
         chk("hold_pc", pc, PCR + 32'd4);
         chk("hold_instr", instr, 32'h0050_0093);
         chk("hold_req", {31'd0, req}, 32'd0);
      end
      stall = 0;
      step();
      chk("unstall_req", {31'd0, req}, 32'd1);
      chk("unstall_addr", addr, PCR + 32'd8);

      // Redirect while pending, ack three cycles later
      mem_block = 1;
      redir = 1; rpc = 32'h0000_0100;
      step();
      redir = 0;
      chk("flush_addr", addr, PCR + 32'd8);
      step();
      step();
      mem_block = 0;
      step();
      chk("drain_addr", addr, 32'h0000_0100);
      chk("drain_valid", {31'd0, valid}, 32'd0);
      wait_valid("w_redir");
      chk("redir_pc", pc, 32'h0000_0100);

      // Redirect coinciding with ack
      mem_lat = 0;
      step();
      chk("c4s_addr", addr, 32'h0000_0104);
      redir = 1; rpc = 32'h0000_0180;
      step();
      redir = 0;
      chk("coinc_valid", {31'd0, valid}, 32'd0);
      chk("coinc_addr", addr, 32'h0000_0180);
      chk("coinc_req", {31'd0, req}, 32'd1);

      // Access fault at 8000_0008, held until redirect to mtvec
      err_en = 1; err_addr = PCR + 32'd8;
      redir = 1; rpc = PCR;
      step();
      redir = 0;
      begin
         int k = 0;
         while (!(valid === 1'b1 && pc === PCR + 32'd8) && k < 30) begin step(); k++; end
      end
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_instr", instr, NOP);
      chk("err_pc", pc, PCR + 32'd8);
      repeat (4) begin
         step();
         chk("err_hold_fault", {31'd0, fault}, 32'd1);
         chk("err_hold_req", {31'd0, req}, 32'd0);
      end
      err_en = 0;
      redir = 1; rpc = 32'h0000_0200;
      step();
      redir = 0;
      chk("mtvec_addr", addr, 32'h0000_0200);
      chk("mtvec_fault", {31'd0, fault}, 32'd0);

      // Misaligned redirect from hold, then reset mid-WAIT
      wait_valid("w_mtvec");
      redir = 1; rpc = 32'h0000_0102;
      step();
      redir = 0;
      chk("mis_req", {31'd0, req}, 32'd0);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_pc", pc, 32'h0000_0102);
      chk("mis_instr", instr, NOP);
      mem_block = 1;
      redir = 1; rpc = 32'h0000_0300;
      step();
      redir = 0;
      step();
      rst = 1;
      step();
      chk_reset("midrst");
      rst = 0;
      step();
      chk("restart_req", {31'd0, req}, 32'd1);
      chk("restart_addr", addr, PCR);

      // Misaligned redirect while a request is outstanding: drained first
      redir = 1; rpc = 32'h0000_0206;
      step();
      redir = 0;
      chk("mdrain_req", {31'd0, req}, 32'd1);
      chk("mdrain_addr", addr, PCR);
      mem_block = 0;
      step();
      chk("mdrain_valid", {31'd0, valid}, 32'd1);
      chk("mdrain_fault", {31'd0, fault}, 32'd1);
      chk("mdrain_pc", pc, 32'h0000_0206);
      chk("mdrain_req2", {31'd0, req}, 32'd0);

      // Random traffic
      rand_lat = 1; rand_data = 1; err_rand = 1;
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         stall = ($urandom_range(0, 9) < 3);
         redir = ($urandom_range(0, 19) == 0);
         rpc   = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         if (i > 0 && i % 700 == 0) rpc = 32'hFFFF_FFFC;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit: produces the 32-bit instruction word and PC that the main-control decoder and the rest of decode consume.
- Talks to instruction memory through a single-outstanding req/ack handshake.
- Holds its output under decode stall.
- Redirects on branch, jump or trap vector, discarding any in-flight fetch.
- Substitutes a canonical NOP whenever no valid instruction is present, so the decoder never flags an illegal-opcode exception on a bubble.

Parameters:
- PC_RESET, 32'h8000_0000, PC of the first fetch after reset.
- XLEN, 32, address/PC width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_stall  in  1  decode/hazard stall; the held instruction is not consumed.
- i_redirect  in  1  redirect request (taken branch, jump, trap/mtvec).
- i_redirect_pc  in  XLEN  redirect target.
- o_imem_req  out  1  memory request; level, held until ack.
- o_imem_addr  out  XLEN  fetch address; stable while o_imem_req=1.
- i_imem_ack  in  1  one-cycle completion; ends the current transaction.
- i_imem_rdata  in  32  instruction word, valid with ack.
- i_imem_err  in  1  access fault, qualified by ack.
- o_valid  out  1  o_instr/o_pc hold a fetched (or faulted) instruction.
- o_instr  out  32  instruction to the decoder; 32'h0000_0013 (NOP) when o_valid=0 or o_fault=1.
- o_pc  out  XLEN  PC of o_instr.
- o_fault  out  1  fetch fault: misaligned target or i_imem_err; meaningful with o_valid.

Behaviour:
- Reset values:
  - state=S_IDLE
  - o_imem_req=0, o_imem_addr=PC_RESET
  - o_valid=0, o_instr=NOP, o_pc=PC_RESET, o_fault=0
  - pending_pc=0
- All outputs are registered.
- i_rst asserted in any state, including mid-transaction, returns to reset values the next edge. A late ack after reset is ignored (memory must tolerate an abandoned request).
- Consume = o_valid & ~i_stall & ~o_fault.
- Priority: i_rst > i_redirect > ack > stall.
- S_IDLE: next cycle -> S_WAIT, o_imem_req=1, o_imem_addr=PC_RESET. The first request is visible on cycle 1 after reset release.
- S_WAIT (req=1):
  - ack & ~err & ~redirect: o_instr<=rdata, o_pc<=o_imem_addr, o_valid<=1, o_fault<=0, req<=0 -> S_HOLD.
  - ack & err & ~redirect: o_valid<=1, o_fault<=1, o_instr<=NOP, o_pc<=o_imem_addr, req<=0 -> S_HOLD.
  - redirect & ack: data discarded; start the new transaction at i_redirect_pc next cycle with req held high; stay in S_WAIT.
  - redirect & ~ack: pending_pc<=i_redirect_pc; keep req high at the old address -> S_FLUSH.
- S_FLUSH (req=1, old address):
  - ack: discard data/err, o_imem_addr<=pending_pc -> S_WAIT.
  - A further redirect overwrites pending_pc; if it coincides with ack, the new i_redirect_pc wins.
- S_HOLD (req=0, o_valid=1):
  - redirect: o_valid<=0, o_fault<=0, o_imem_addr<=i_redirect_pc, req<=1 -> S_WAIT.
  - consume: o_valid<=0, o_imem_addr<=o_pc+4 (mod 2^XLEN, wrap from 32'hFFFF_FFFC to 0), req<=1 -> S_WAIT.
  - stall, or o_fault=1: hold all outputs unchanged. A faulted instruction never advances; only redirect leaves it.
- Misaligned redirect (i_redirect_pc[1:0]!=0), in any state:
  - No memory request is issued for it.
  - In S_WAIT/S_FLUSH, the outstanding request is first drained (via S_FLUSH).
  - Then o_valid<=1, o_fault<=1, o_pc<=target, o_instr=NOP -> S_HOLD.
- While o_valid=0, o_instr=NOP.
- Throughput: one instruction per 2 cycles with zero-wait memory. Latency from ack to o_valid is 1 cycle.
- Redirect to stall interaction: the redirect is taken regardless of i_stall.

Decomposition:
- Shared defines header holds:
  - INSTR_NOP (32'h0000_0013)
  - state encoding (S_IDLE, S_WAIT, S_FLUSH, S_HOLD, 2 bits)
  - PC_RESET default
  - XLEN
- No sub-module; next-PC selection stays inline.

Test Plan:
- Reset release, memory acks every request 1 cycle after req with rdata=32'h00500093 -> req at cycle 1 addr 8000_0000; o_valid at cycle 3 with o_pc=8000_0000, o_instr=00500093; next req addr 8000_0004.
- o_valid=1 with i_stall held 5 cycles -> o_instr/o_pc unchanged, o_imem_req=0 throughout; stall drops -> req for o_pc+4 the next cycle.
- Redirect to 0000_0100 while req pending without ack, ack arrives 3 cycles later -> old data never appears on o_valid; o_imem_addr becomes 0000_0100 the cycle after ack.
- Redirect coinciding with ack -> rdata discarded, o_valid stays 0, new req to the redirect target the next cycle.
- Ack with i_imem_err=1 at addr 8000_0008 -> o_valid=1, o_fault=1, o_instr=NOP; outputs hold with i_stall=0 until redirect to mtvec 0000_0200.
- Redirect to 0000_0102, then i_rst mid-WAIT -> first: no req issued, o_fault=1, o_pc=0000_0102; second: all outputs return to reset values the next edge, and fetch restarts at PC_RESET.
